// File: rtl/oneapi_avalon_to_axi_gasket_if.sv
// Bus bundle for the Avalon-ST to AXI4-Stream gasket.
// The slave modport is the gasket's view (Avalon sink in, AXI source out);
// the master modport is the surrounding environment's view.
interface oneapi_avalon_to_axi_gasket_if #(
  parameter int PARALLEL_PIXELS     = 2,
  parameter int BITS_PER_CHANNEL    = 10,
  parameter int CHANNELS            = 3,
  parameter int BITS_PER_CHANNEL_AV = 16
);
  localparam int BITS_PER_PIXEL_AV  = BITS_PER_CHANNEL_AV * CHANNELS;
  localparam int BITS_AV            = BITS_PER_PIXEL_AV * PARALLEL_PIXELS;
  localparam int EMPTY_BITS         = $clog2(BITS_AV / 8);
  localparam int BITS_PER_PIXEL_AXI = 8 * ((CHANNELS * BITS_PER_CHANNEL + 7) / 8);
  localparam int BITS_AXI           = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS;
  localparam int TUSER_BITS         = (BITS_AXI + 7) / 8;

  logic                  asi_ready;
  logic                  asi_valid;
  logic [BITS_AV-1:0]    asi_data;
  logic                  asi_startofpacket;
  logic                  asi_endofpacket;
  logic [EMPTY_BITS-1:0] asi_empty;

  logic                  axm_tready;
  logic                  axm_tvalid;
  logic [BITS_AXI-1:0]   axm_tdata;
  logic                  axm_tlast;
  logic [TUSER_BITS-1:0] axm_tuser;

  modport slave (
    output asi_ready,
    input  asi_valid, asi_data, asi_startofpacket, asi_endofpacket, asi_empty,
    input  axm_tready,
    output axm_tvalid, axm_tdata, axm_tlast, axm_tuser
  );

  modport master (
    input  asi_ready,
    output asi_valid, asi_data, asi_startofpacket, asi_endofpacket, asi_empty,
    output axm_tready,
    input  axm_tvalid, axm_tdata, axm_tlast, axm_tuser
  );
endinterface

// File: rtl/oneapi_avalon_to_axi_gasket.sv
// Avalon-ST video to oneAPI AXI4-Stream gasket.
// Strips each Avalon channel slot down to its significant bits, packs the
// channels into byte-aligned AXI pixels, maps sop/eop onto tuser[0]/tlast,
// and only lets complete frames through (beats before the first sop are
// dropped). Output side is a registered two-entry skid buffer.
// Optional feature: define AV_TO_AXI_STATUS_EN to add saturating status
// counters for frames, dropped beats and early sops.
module oneapi_avalon_to_axi_gasket #(
  parameter int PARALLEL_PIXELS     = 2,
  parameter int BITS_PER_CHANNEL    = 10,
  parameter int CHANNELS            = 3,
  parameter int BITS_PER_CHANNEL_AV = 16
) (
  input logic csi_clk,
  input logic rsi_reset,
  oneapi_avalon_to_axi_gasket_if.slave bus
`ifdef AV_TO_AXI_STATUS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_dropped_beats,
  output logic [15:0] stat_early_sop
`endif
);

  localparam int BITS_PER_PIXEL_AV  = BITS_PER_CHANNEL_AV * CHANNELS;
  localparam int BITS_PER_PIXEL_AXI = 8 * ((CHANNELS * BITS_PER_CHANNEL + 7) / 8);
  localparam int BITS_AXI           = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS;
  localparam int TUSER_BITS         = (BITS_AXI + 7) / 8;

  typedef enum logic {
    WAIT_SOP,
    IN_PKT
  } state_t;

  state_t state;
  state_t state_next;

  logic beat_accepted;
  logic beat_forward;
  logic beat_drop;
  logic beat_early_sop;

  logic [BITS_AXI-1:0] packed_data;
  int                  invalid_px;

  logic                ready_q;
  logic                out_valid;
  logic [BITS_AXI-1:0] out_data;
  logic                out_last;
  logic                out_sof;
  logic                skid_valid;
  logic [BITS_AXI-1:0] skid_data;
  logic                skid_last;
  logic                skid_sof;
  logic                pop;
  logic [1:0]          occ_next;

  // Unpad and pack channels; on an eop beat blank the lanes that empty marks unused
  always_comb begin
    packed_data = '0;
    invalid_px  = 0;
    if (bus.asi_endofpacket)
      invalid_px = (int'(bus.asi_empty) * 8) / BITS_PER_PIXEL_AV;
    for (int p = 0; p < PARALLEL_PIXELS; p++) begin
      if (p < PARALLEL_PIXELS - invalid_px) begin
        for (int c = 0; c < CHANNELS; c++) begin
          packed_data[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL] =
            bus.asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL];
        end
      end
    end
  end

  // Frame-alignment state register
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) state <= WAIT_SOP;
    else           state <= state_next;
  end

  // Decide per accepted beat whether it is forwarded or dropped, and track frame state
  always_comb begin
    state_next     = state;
    beat_forward   = 1'b0;
    beat_drop      = 1'b0;
    beat_early_sop = 1'b0;
    beat_accepted  = bus.asi_valid && ready_q;
    if (beat_accepted) begin
      case (state)
        WAIT_SOP: begin
          if (bus.asi_startofpacket) begin
            beat_forward = 1'b1;
            if (!bus.asi_endofpacket) state_next = IN_PKT;
          end else begin
            beat_drop = 1'b1;
          end
        end
        IN_PKT: begin
          beat_forward   = 1'b1;
          beat_early_sop = bus.asi_startofpacket;
          if (bus.asi_endofpacket) state_next = WAIT_SOP;
        end
        default: state_next = WAIT_SOP;
      endcase
    end
  end

  // Occupancy after this cycle decides whether another beat can be taken next cycle
  always_comb begin
    pop      = out_valid && bus.axm_tready;
    occ_next = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, beat_forward} - {1'b0, pop};
  end

  // Two-entry skid buffer: output register refills from skid first, then from the input
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      ready_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sof    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_sof   <= 1'b0;
    end else begin
      ready_q <= (occ_next <= 2'd1);
      if (pop || !out_valid) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_last   <= skid_last;
          out_sof    <= skid_sof;
          skid_valid <= beat_forward;
          if (beat_forward) begin
            skid_data <= packed_data;
            skid_last <= bus.asi_endofpacket;
            skid_sof  <= bus.asi_startofpacket;
          end
        end else if (beat_forward) begin
          out_valid <= 1'b1;
          out_data  <= packed_data;
          out_last  <= bus.asi_endofpacket;
          out_sof   <= bus.asi_startofpacket;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (beat_forward) begin
        skid_valid <= 1'b1;
        skid_data  <= packed_data;
        skid_last  <= bus.asi_endofpacket;
        skid_sof   <= bus.asi_startofpacket;
      end
    end
  end

  assign bus.asi_ready  = ready_q;
  assign bus.axm_tvalid = out_valid;
  assign bus.axm_tdata  = out_data;
  assign bus.axm_tlast  = out_last;
  assign bus.axm_tuser  = {{(TUSER_BITS-1){1'b0}}, out_sof};

`ifdef AV_TO_AXI_STATUS_EN
  // Saturating event counters for frame starts, dropped beats and early sops
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      stat_frames        <= '0;
      stat_dropped_beats <= '0;
      stat_early_sop     <= '0;
    end else begin
      if (beat_forward && bus.asi_startofpacket && stat_frames != 16'hFFFF)
        stat_frames <= stat_frames + 16'd1;
      if (beat_drop && stat_dropped_beats != 16'hFFFF)
        stat_dropped_beats <= stat_dropped_beats + 16'd1;
      if (beat_early_sop && stat_early_sop != 16'hFFFF)
        stat_early_sop <= stat_early_sop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oneapi_avalon_to_axi_gasket.sv
// Directed self-checking bench for oneapi_avalon_to_axi_gasket.
// Inputs are driven 1ns after each rising edge and outputs are sampled at
// the same point, so every check sees the state registered by the edge just
// passed. Expected values are hand-computed constants.
module tb_oneapi_avalon_to_axi_gasket;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  oneapi_avalon_to_axi_gasket_if bus ();

`ifdef AV_TO_AXI_STATUS_EN
  logic [15:0] stat_frames;
  logic [15:0] stat_dropped_beats;
  logic [15:0] stat_early_sop;
`endif

  oneapi_avalon_to_axi_gasket dut (
    .csi_clk   (clk),
    .rsi_reset (rst),
    .bus       (bus)
`ifdef AV_TO_AXI_STATUS_EN
    ,
    .stat_frames        (stat_frames),
    .stat_dropped_beats (stat_dropped_beats),
    .stat_early_sop     (stat_early_sop)
`endif
  );

  always #5 clk = ~clk;

  // Pixel 0 = {13,12,11}, pixel 1 = {23,22,21} in 16-bit slots
  localparam logic [95:0] D2 = {16'h0023, 16'h0022, 16'h0021, 16'h0013, 16'h0012, 16'h0011};
  localparam logic [63:0] E2 = 64'h0230_8821_0130_4811;
  // Every slot carries value v; packed pixel = v<<20 | v<<10 | v
  localparam logic [95:0] DV1 = {6{16'h0001}};
  localparam logic [95:0] DV2 = {6{16'hFC02}};
  localparam logic [95:0] DV3 = {6{16'h0003}};
  localparam logic [95:0] DV4 = {6{16'h0004}};
  localparam logic [63:0] EV1 = 64'h0010_0401_0010_0401;
  localparam logic [63:0] EV2 = 64'h0020_0802_0020_0802;
  localparam logic [63:0] EV3 = 64'h0030_0C03_0030_0C03;
  localparam logic [63:0] EV4 = 64'h0040_1004_0040_1004;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [95:0] data, input logic sop, input logic eop, input logic [3:0] empty);
    bus.asi_valid         = 1'b1;
    bus.asi_data          = data;
    bus.asi_startofpacket = sop;
    bus.asi_endofpacket   = eop;
    bus.asi_empty         = empty;
  endtask

  task automatic idle();
    bus.asi_valid         = 1'b0;
    bus.asi_data          = '0;
    bus.asi_startofpacket = 1'b0;
    bus.asi_endofpacket   = 1'b0;
    bus.asi_empty         = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Reset held 3 clocks: all outputs low; ready rises one clock after release
  task automatic test_reset();
    idle();
    bus.axm_tready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (bus.asi_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", bus.asi_ready); end
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid: got %b want 0", bus.axm_tvalid); end
    total++; if (bus.axm_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast: got %b want 0", bus.axm_tlast); end
    total++; if (bus.axm_tuser !== 8'h00) begin bad++; $display("[TB] FAIL reset_tuser: got %h want 00", bus.axm_tuser); end
    total++; if (bus.axm_tdata !== 64'h0) begin bad++; $display("[TB] FAIL reset_tdata: got %h want 0", bus.axm_tdata); end
    rst = 1'b0;
    #1;
    total++; if (bus.asi_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_ready_early: got %b want 0", bus.asi_ready); end
    tick();
    total++; if (bus.asi_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready: got %b want 1", bus.asi_ready); end
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL release_tvalid: got %b want 0", bus.axm_tvalid); end
  endtask

  // Single sop+eop beat appears one clock later with packed data
  task automatic test_single();
    bus.axm_tready = 1'b1;
    drive(D2, 1'b1, 1'b1, 4'd0);
    tick();
    idle();
    total++; if (bus.axm_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL single_tvalid: got %b want 1", bus.axm_tvalid); end
    total++; if (bus.axm_tdata !== E2) begin bad++; $display("[TB] FAIL single_tdata: got %h want %h", bus.axm_tdata, E2); end
    total++; if (bus.axm_tuser !== 8'h01) begin bad++; $display("[TB] FAIL single_tuser: got %h want 01", bus.axm_tuser); end
    total++; if (bus.axm_tlast !== 1'b1) begin bad++; $display("[TB] FAIL single_tlast: got %b want 1", bus.axm_tlast); end
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain: got %b want 0", bus.axm_tvalid); end
  endtask

  // Four-beat frame with tready low for 5 clocks: ready drops after 2 beats, order and stability kept
  task automatic test_backpressure();
    bus.axm_tready = 1'b0;
    drive(DV1, 1'b1, 1'b0, 4'd0);
    tick();
    total++; if (bus.asi_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_one: got %b want 1", bus.asi_ready); end
    total++; if (bus.axm_tdata !== EV1) begin bad++; $display("[TB] FAIL bp_first: got %h want %h", bus.axm_tdata, EV1); end
    drive(DV2, 1'b0, 1'b0, 4'd0);
    tick();
    drive(DV3, 1'b0, 1'b0, 4'd0);
    total++; if (bus.asi_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_full: got %b want 0", bus.asi_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.axm_tdata !== EV1 || bus.axm_tvalid !== 1'b1 || bus.axm_tuser !== 8'h01)
        begin bad++; $display("[TB] FAIL bp_hold%0d: got v=%b d=%h u=%h want v=1 d=%h u=01", i, bus.axm_tvalid, bus.axm_tdata, bus.axm_tuser, EV1); end
      total++; if (bus.asi_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold_ready%0d: got %b want 0", i, bus.asi_ready); end
    end
    bus.axm_tready = 1'b1;
    tick();
    total++; if (bus.axm_tdata !== EV2 || bus.axm_tuser !== 8'h00 || bus.axm_tlast !== 1'b0)
      begin bad++; $display("[TB] FAIL bp_beat1: got d=%h u=%h l=%b want d=%h u=00 l=0", bus.axm_tdata, bus.axm_tuser, bus.axm_tlast, EV2); end
    total++; if (bus.asi_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back: got %b want 1", bus.asi_ready); end
    tick();
    drive(DV4, 1'b0, 1'b1, 4'd0);
    total++; if (bus.axm_tdata !== EV3 || bus.axm_tvalid !== 1'b1 || bus.axm_tlast !== 1'b0)
      begin bad++; $display("[TB] FAIL bp_beat2: got v=%b d=%h l=%b want v=1 d=%h l=0", bus.axm_tvalid, bus.axm_tdata, bus.axm_tlast, EV3); end
    tick();
    idle();
    total++; if (bus.axm_tdata !== EV4 || bus.axm_tlast !== 1'b1 || bus.axm_tuser !== 8'h00)
      begin bad++; $display("[TB] FAIL bp_beat3: got d=%h l=%b u=%h want d=%h l=1 u=00", bus.axm_tdata, bus.axm_tlast, bus.axm_tuser, EV4); end
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", bus.axm_tvalid); end
  endtask

  // Beats before sop are dropped, including a stray eop
  task automatic test_drop();
    do_reset();
    bus.axm_tready = 1'b1;
    drive(DV1, 1'b0, 1'b0, 4'd0);
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL drop_first: got %b want 0", bus.axm_tvalid); end
    drive(DV2, 1'b0, 1'b1, 4'd0);
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL drop_second: got %b want 0", bus.axm_tvalid); end
    drive(D2, 1'b1, 1'b1, 4'd0);
    tick();
    idle();
    total++; if (bus.axm_tvalid !== 1'b1 || bus.axm_tdata !== E2 || bus.axm_tuser !== 8'h01 || bus.axm_tlast !== 1'b1)
      begin bad++; $display("[TB] FAIL drop_frame: got v=%b d=%h u=%h l=%b want v=1 d=%h u=01 l=1", bus.axm_tvalid, bus.axm_tdata, bus.axm_tuser, bus.axm_tlast, E2); end
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL drop_drain: got %b want 0", bus.axm_tvalid); end
`ifdef AV_TO_AXI_STATUS_EN
    total++; if (stat_dropped_beats !== 16'd2) begin bad++; $display("[TB] FAIL stat_dropped: got %0d want 2", stat_dropped_beats); end
    total++; if (stat_frames !== 16'd1) begin bad++; $display("[TB] FAIL stat_frames_drop: got %0d want 1", stat_frames); end
`endif
  endtask

  // sop, data, sop, eop: second sop starts a new frame without tlast on the first
  task automatic test_early_sop();
    logic [95:0] din [4];
    logic        sop [4];
    logic        eop [4];
    logic [63:0] exp_d [4];
    logic [7:0]  exp_u [4];
    logic        exp_l [4];
    din = '{DV1, DV2, DV3, DV4};
    sop = '{1'b1, 1'b0, 1'b1, 1'b0};
    eop = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_d = '{EV1, EV2, EV3, EV4};
    exp_u = '{8'h01, 8'h00, 8'h01, 8'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.axm_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(din[i], sop[i], eop[i], 4'd0);
      tick();
      total++; if (bus.axm_tvalid !== 1'b1 || bus.axm_tdata !== exp_d[i] || bus.axm_tuser !== exp_u[i] || bus.axm_tlast !== exp_l[i])
        begin bad++; $display("[TB] FAIL early_beat%0d: got v=%b d=%h u=%h l=%b want v=1 d=%h u=%h l=%b", i, bus.axm_tvalid, bus.axm_tdata, bus.axm_tuser, bus.axm_tlast, exp_d[i], exp_u[i], exp_l[i]); end
    end
    idle();
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL early_drain: got %b want 0", bus.axm_tvalid); end
`ifdef AV_TO_AXI_STATUS_EN
    total++; if (stat_early_sop !== 16'd1) begin bad++; $display("[TB] FAIL stat_early: got %0d want 1", stat_early_sop); end
    total++; if (stat_frames !== 16'd2) begin bad++; $display("[TB] FAIL stat_frames_early: got %0d want 2", stat_frames); end
`endif
  endtask

  // empty only matters on eop beats; 6 bytes blanks pixel 1, 5 blanks nothing, 12 blanks both
  task automatic test_empty();
    logic        sop [4];
    logic        eop [4];
    logic [3:0]  emp [4];
    logic [63:0] exp_d [4];
    sop = '{1'b1, 1'b0, 1'b1, 1'b1};
    eop = '{1'b0, 1'b1, 1'b1, 1'b1};
    emp = '{4'd6, 4'd5, 4'd6, 4'd12};
    exp_d = '{E2, E2, 64'h0000_0000_0130_4811, 64'h0};
    bus.axm_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(D2, sop[i], eop[i], emp[i]);
      tick();
      total++; if (bus.axm_tvalid !== 1'b1 || bus.axm_tdata !== exp_d[i])
        begin bad++; $display("[TB] FAIL empty_beat%0d: got v=%b d=%h want v=1 d=%h", i, bus.axm_tvalid, bus.axm_tdata, exp_d[i]); end
    end
    idle();
    tick();
  endtask

  // Reset with a full skid buffer: everything discarded, next output is a fresh frame
  task automatic test_reset_midframe();
    bus.axm_tready = 1'b0;
    drive(DV1, 1'b1, 1'b0, 4'd0);
    tick();
    drive(DV2, 1'b0, 1'b0, 4'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    total++; if (bus.axm_tvalid !== 1'b0 || bus.asi_ready !== 1'b0 || bus.axm_tdata !== 64'h0)
      begin bad++; $display("[TB] FAIL midreset_async: got v=%b r=%b d=%h want v=0 r=0 d=0", bus.axm_tvalid, bus.asi_ready, bus.axm_tdata); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (bus.asi_ready !== 1'b1 || bus.axm_tvalid !== 1'b0)
      begin bad++; $display("[TB] FAIL midreset_release: got r=%b v=%b want r=1 v=0", bus.asi_ready, bus.axm_tvalid); end
    bus.axm_tready = 1'b1;
    drive(DV3, 1'b0, 1'b0, 4'd0);
    tick();
    total++; if (bus.axm_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_drop: got %b want 0", bus.axm_tvalid); end
    drive(D2, 1'b1, 1'b1, 4'd0);
    tick();
    idle();
    total++; if (bus.axm_tvalid !== 1'b1 || bus.axm_tdata !== E2 || bus.axm_tuser !== 8'h01 || bus.axm_tlast !== 1'b1)
      begin bad++; $display("[TB] FAIL midreset_frame: got v=%b d=%h u=%h l=%b want v=1 d=%h u=01 l=1", bus.axm_tvalid, bus.axm_tdata, bus.axm_tuser, bus.axm_tlast, E2); end
    tick();
  endtask

  initial begin
    idle();
    bus.axm_tready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_drop();
    test_early_sop();
    test_empty();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
